fragment_hazard_gate: RTL and testbench



---
 rtl/fragment_hazard_gate.sv | 98 +++++++++
 tb/tb_fragment_hazard_gate.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fragment_hazard_gate.sv
// Stalls a fragment whose framebuffer index is still inside the pixel pipeline's read-modify-write window.
// Optional stall counter (stallCycles/statsClear) is built when FRAGMENT_HAZARD_GATE_STATS_EN is defined.
module fragment_hazard_gate #(
  parameter int TDATA_WIDTH    = 256,
  parameter int INDEX_POS      = 0,
  parameter int INDEX_WIDTH    = 14,
  parameter int PIPELINE_DEPTH = 24
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   confHazardEnable,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
  input  logic                   statsClear,
  output logic [31:0]            stallCycles,
`endif
  output logic                   fragmentsInFlight
);

  logic                      r_h_valid;
  logic                      r_h_tlast;
  logic [TDATA_WIDTH-1:0]    r_h_tdata;
  logic [PIPELINE_DEPTH-1:0] r_t_valid;
  logic [INDEX_WIDTH-1:0]    r_t_index [PIPELINE_DEPTH];
  logic                      r_in_flight;

  logic [INDEX_WIDTH-1:0]    w_h_index;
  logic                      w_match;
  logic                      w_hazard;
  logic                      w_issue;
  logic                      w_s_hs;
  logic [PIPELINE_DEPTH-1:0] w_t_valid_next;

  assign w_h_index = r_h_tdata[INDEX_POS +: INDEX_WIDTH];

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < PIPELINE_DEPTH; i++) begin
      if (r_t_valid[i] && (r_t_index[i] == w_h_index)) w_match = 1'b1;
    end
  end

  assign w_hazard       = confHazardEnable & w_match;
  assign m_axis_tvalid  = r_h_valid & ~w_hazard;
  assign m_axis_tlast   = r_h_tlast;
  assign m_axis_tdata   = r_h_tdata;
  assign w_issue        = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready  = ~r_h_valid | w_issue;
  assign w_s_hs         = s_axis_tvalid & s_axis_tready;
  assign w_t_valid_next = {r_t_valid[PIPELINE_DEPTH-2:0], w_issue};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_h_valid   <= 1'b0;
      r_t_valid   <= '0;
      r_in_flight <= 1'b0;
    end else begin
      if (w_s_hs)       r_h_valid <= 1'b1;
      else if (w_issue) r_h_valid <= 1'b0;
      r_t_valid   <= w_t_valid_next;
      r_in_flight <= |w_t_valid_next;
    end
  end

  // NOTE: payload and index storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge aclk) begin
    if (w_s_hs) begin
      r_h_tlast <= s_axis_tlast;
      r_h_tdata <= s_axis_tdata;
    end
    r_t_index[0] <= w_h_index;
    for (int i = 1; i < PIPELINE_DEPTH; i++) r_t_index[i] <= r_t_index[i-1];
  end

  assign fragmentsInFlight = r_in_flight;

`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
  logic [31:0] r_stall_cycles;

  // Clear wins over a same-cycle increment; the count saturates rather than wrapping.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset)                                                r_stall_cycles <= '0;
    else if (statsClear)                                      r_stall_cycles <= '0;
    else if (r_h_valid && w_hazard && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stallCycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fragment_hazard_gate.sv
// Self-checking bench for fragment_hazard_gate: directed scenarios plus randomized traffic against a
// reference model that tracks the last issue cycle of each framebuffer index.
module tb_fragment_hazard_gate;

  localparam int DW    = 256;
  localparam int IW    = 14;
  localparam int DEPTH = 24;

  logic          aclk = 1'b0;
  logic          reset;
  logic          en;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          in_flight;
  logic          stats_clear;
  logic [31:0]   stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  fragment_hazard_gate #(
    .TDATA_WIDTH(DW), .INDEX_POS(0), .INDEX_WIDTH(IW), .PIPELINE_DEPTH(DEPTH)
  ) dut (
    .aclk              (aclk),
    .reset             (reset),
    .confHazardEnable  (en),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tlast      (s_last),
    .s_axis_tdata      (s_data),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tlast      (m_last),
    .m_axis_tdata      (m_data),
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
    .statsClear        (stats_clear),
    .stallCycles       (stall_cycles),
`endif
    .fragmentsInFlight (in_flight)
  );

`ifndef FRAGMENT_HAZARD_GATE_STATS_EN
  assign stall_cycles = '0;
`endif

  function automatic logic [DW-1:0] rand_data(input int idx);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    d[IW-1:0] = idx[IW-1:0];
    return d;
  endfunction

  // One clock cycle: drive just after the edge, return mid-cycle for sampling.
  task automatic step(input bit v, input bit l, input logic [DW-1:0] d, input bit rdy, input bit e);
    @(posedge aclk);
    #1;
    s_valid = v; s_last = l; s_data = d; m_ready = rdy; en = e;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1; stats_clear = 1'b0;
    #12;
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_tvalid got %0b exp 0", m_valid); end
    checks++; if (s_ready !== 1'b1)   begin errors++; $display("FAIL reset_s_tready got %0b exp 1", s_ready); end
    checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL reset_in_flight got %0b exp 0", in_flight); end
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
`endif
    @(negedge aclk) reset = 1'b0;
  endtask

  task automatic test_distinct;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) step(1'b1, i == 16, rand_data(i), 1'b1, 1'b1);
      else         step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL distinct_s_tready c%0d got %0b exp 1", i, s_ready); end
      checks++; if (m_valid !== (i > 1)) begin errors++; $display("FAIL distinct_m_tvalid c%0d got %0b exp %0b", i, m_valid, i > 1); end
      if (i > 1) begin
        checks++; if (m_data[IW-1:0] !== IW'(i - 1)) begin errors++; $display("FAIL distinct_index c%0d got %h exp %h", i, m_data[IW-1:0], i - 1); end
        checks++; if (m_last !== (i == 17)) begin errors++; $display("FAIL distinct_tlast c%0d got %0b exp %0b", i, m_last, i == 17); end
      end
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_same_index;
    int issue2;
    stats_clear = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    stats_clear = 1'b0;
    step(1'b1, 1'b0, rand_data('h123), 1'b1, 1'b1);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL same_c0_m_tvalid got %0b exp 0", m_valid); end
    step(1'b1, 1'b1, rand_data('h123), 1'b1, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL same_c1_m_tvalid got %0b exp 1", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL same_c1_s_tready got %0b exp 1", s_ready); end
    issue2 = -1;
    for (int c = 2; c <= 40; c++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (m_valid === 1'b1 && issue2 < 0) issue2 = c;
    end
    checks++; if (issue2 !== 26) begin errors++; $display("FAIL same_second_issue got cycle %0d exp 26", issue2); end
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
    checks++; if (stall_cycles !== 32'd24) begin errors++; $display("FAIL same_stall got %0d exp 24", stall_cycles); end
`endif
  endtask

  task automatic test_hazard_disabled;
    for (int c = 0; c <= 5; c++) begin
      step(c < 4, 1'b0, rand_data('h42), 1'b1, 1'b0);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hzoff_s_tready c%0d got %0b exp 1", c, s_ready); end
      checks++; if (m_valid !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL hzoff_m_tvalid c%0d got %0b exp %0b", c, m_valid, c >= 1 && c <= 4); end
    end
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
    checks++; if (stall_cycles !== 32'd24) begin errors++; $display("FAIL hzoff_stall got %0d exp 24", stall_cycles); end
`endif
  endtask

  task automatic test_interleaved;
    int iss_c[$];
    int iss_i[$];
    int exp_c[3] = '{1, 2, 26};
    int exp_i[3] = '{5, 6, 5};
    for (int c = 0; c <= 40; c++) begin
      step(c < 3, 1'b0, rand_data(c == 1 ? 6 : 5), 1'b1, 1'b1);
      if (m_valid === 1'b1) begin
        iss_c.push_back(c);
        iss_i.push_back(int'(m_data[IW-1:0]));
      end
    end
    checks++;
    if (iss_c.size() != 3) begin
      errors++; $display("FAIL interleave_count got %0d exp 3", iss_c.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (iss_c[k] != exp_c[k]) begin errors++; $display("FAIL interleave_cycle%0d got %0d exp %0d", k, iss_c[k], exp_c[k]); end
        checks++; if (iss_i[k] != exp_i[k]) begin errors++; $display("FAIL interleave_index%0d got %h exp %h", k, iss_i[k], exp_i[k]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d7, d8;
    d7 = rand_data('h7);
    d8 = rand_data('h8);
    step(1'b1, 1'b0, d7, 1'b0, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      step(1'b1, 1'b0, d8, 1'b0, 1'b1);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_tvalid c%0d got %0b exp 1", c, m_valid); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_tready c%0d got %0b exp 0", c, s_ready); end
      checks++; if (m_data !== d7) begin errors++; $display("FAIL bp_hold_data c%0d got %h exp %h", c, m_data, d7); end
    end
    checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL bp_in_flight_idle got %0b exp 0", in_flight); end
    step(1'b1, 1'b0, d8, 1'b1, 1'b1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_tready got %0b exp 1", s_ready); end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++; if (m_data !== d8 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_next_frag got v%0b %h exp v1 %h", m_valid, m_data, d8); end
    checks++; if (in_flight !== 1'b1) begin errors++; $display("FAIL bp_in_flight_busy got %0b exp 1", in_flight); end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_stall;
    logic [DW-1:0] dn;
    step(1'b1, 1'b0, rand_data('h33), 1'b1, 1'b1);
    step(1'b1, 1'b0, rand_data('h33), 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_pre c%0d got v%0b r%0b exp v0 r0", c, m_valid, s_ready); end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL rst_async_m_tvalid got %0b exp 0", m_valid); end
    checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL rst_async_in_flight got %0b exp 0", in_flight); end
    checks++; if (s_ready !== 1'b1)   begin errors++; $display("FAIL rst_async_s_tready got %0b exp 1", s_ready); end
    @(negedge aclk) reset = 1'b0;
    dn = rand_data('h33);
    step(1'b1, 1'b0, dn, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++; if (m_valid !== 1'b1 || m_data !== dn) begin errors++; $display("FAIL rst_after_issue got v%0b %h exp v1 %h", m_valid, m_data, dn); end
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_after_stall got %0d exp 0", stall_cycles); end
`endif
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  // Reference: a fragment is blocked while its index was issued within the last DEPTH cycles.
  task automatic test_random;
    bit            mh_valid, mh_last;
    logic [DW-1:0] mh_data;
    int            last_issue[int];
    int            last_any, cyc, exp_stall, key, li;
    bit            v, l, r, e, haz, exp_mv, iss, exp_sr, exp_if;
    logic [DW-1:0] d;
    @(negedge aclk) reset = 1'b1;
    @(negedge aclk) reset = 1'b0;
    mh_valid = 1'b0; mh_last = 1'b0; mh_data = '0;
    last_any = -1000; cyc = 0; exp_stall = 0;
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 3) != 0);
      l = $urandom_range(0, 1) != 0;
      r = ($urandom_range(0, 4) != 0);
      e = ($urandom_range(0, 9) != 0);
      d = rand_data($urandom_range(0, 5));
      step(v, l, d, r, e);
      key    = int'(mh_data[IW-1:0]);
      li     = last_issue.exists(key) ? last_issue[key] : -1000;
      haz    = e && mh_valid && (cyc - li <= DEPTH);
      exp_mv = mh_valid && !haz;
      iss    = exp_mv && r;
      exp_sr = !mh_valid || iss;
      exp_if = (cyc - last_any) <= DEPTH;
      checks++; if (m_valid !== exp_mv)   begin errors++; $display("FAIL rnd_m_tvalid n%0d got %0b exp %0b", n, m_valid, exp_mv); end
      checks++; if (s_ready !== exp_sr)   begin errors++; $display("FAIL rnd_s_tready n%0d got %0b exp %0b", n, s_ready, exp_sr); end
      checks++; if (in_flight !== exp_if) begin errors++; $display("FAIL rnd_in_flight n%0d got %0b exp %0b", n, in_flight, exp_if); end
      if (exp_mv) begin
        checks++; if (m_data !== mh_data || m_last !== mh_last) begin errors++; $display("FAIL rnd_payload n%0d got %0b %h exp %0b %h", n, m_last, m_data, mh_last, mh_data); end
      end
`ifdef FRAGMENT_HAZARD_GATE_STATS_EN
      checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL rnd_stall n%0d got %0d exp %0d", n, stall_cycles, exp_stall); end
`endif
      if (mh_valid && haz) exp_stall++;
      if (iss) begin
        last_issue[key] = cyc;
        last_any = cyc;
      end
      if (v && exp_sr) begin
        mh_valid = 1'b1; mh_data = d; mh_last = l;
      end else if (iss) begin
        mh_valid = 1'b0;
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset;
    test_distinct;
    test_same_index;
    test_hazard_disabled;
    test_interleaved;
    test_backpressure;
    test_reset_mid_stall;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
